regfile_wr_arbiter: RTL and testbench

Shares the single register-file write port between two writeback requesters (execute and memory stages) using round-robin arbitration with a valid/ready handshake. Drives registered writeReg/writeData/regWrEn into regfile and supplies same-cycle forwarding for both read ports, so a value being written is visible one cycle before the regfile returns it. Writes targeting X31 are accepted but never reach the regfile.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/rr_arb2.sv | 15 +
 rtl/regfile_wr_arbiter.sv | 92 +++++++++
 tb/tb_regfile_wr_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants and writeback request type
package regfile_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  // One writeback request: destination register and the value to write.
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter, purely combinational
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Sole requester wins; under contention the one not granted last time wins.
  always_comb begin
    grant    = 2'b00;
    grant[0] = valid[0] & (~valid[1] | last_grant);
    grant[1] = valid[1] & (~valid[0] | ~last_grant);
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - shares the regfile write port between execute and memory writeback
module regfile_wr_arbiter
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0Valid,
  input  logic [ADDR_W-1:0] req0Reg,
  input  logic [DATA_W-1:0] req0Data,
  output logic              req0Ready,
  input  logic              req1Valid,
  input  logic [ADDR_W-1:0] req1Reg,
  input  logic [DATA_W-1:0] req1Data,
  output logic              req1Ready,
  input  logic [ADDR_W-1:0] readReg0,
  input  logic [ADDR_W-1:0] readReg1,
  output logic              fwdHit0,
  output logic              fwdHit1,
  output logic [DATA_W-1:0] fwdData0,
  output logic [DATA_W-1:0] fwdData1,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              regWrEn
);

  wr_req_t           req0, req1;
  logic [1:0]        arb_grant;
  logic [1:0]        grant;
  logic              last_grant_d, last_grant_q;
  logic [ADDR_W-1:0] write_reg_d, write_reg_q;
  logic [DATA_W-1:0] write_data_d, write_data_q;
  logic              reg_wr_en_d, reg_wr_en_q;

  assign req0 = '{rd: req0Reg, data: req0Data};
  assign req1 = '{rd: req1Reg, data: req1Data};

  rr_arb2 u_arb (
    .valid      ({req1Valid, req0Valid}),
    .last_grant (last_grant_q),
    .grant      (arb_grant)
  );

  // No grants while reset is held so nothing is handshaken and then dropped.
  assign grant     = reset_n ? arb_grant : 2'b00;
  assign req0Ready = grant[0];
  assign req1Ready = grant[1];

  // Next-state: load the granted request; X31 loads the port but never enables the write.
  always_comb begin
    last_grant_d = last_grant_q;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    reg_wr_en_d  = 1'b0;
    if (grant[0]) begin
      last_grant_d = 1'b0;
      write_reg_d  = req0.rd;
      write_data_d = req0.data;
      reg_wr_en_d  = (req0.rd != ZERO_REG);
    end else if (grant[1]) begin
      last_grant_d = 1'b1;
      write_reg_d  = req1.rd;
      write_data_d = req1.data;
      reg_wr_en_d  = (req1.rd != ZERO_REG);
    end
  end

  // State registers; reset favours requester 0 at the first contention.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      write_reg_q  <= '0;
      write_data_q <= '0;
      reg_wr_en_q  <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      reg_wr_en_q  <= reg_wr_en_d;
    end
  end

  assign writeReg  = write_reg_q;
  assign writeData = write_data_q;
  assign regWrEn   = reg_wr_en_q;

  // The in-flight write is visible to readers one cycle before the regfile has it.
  assign fwdHit0  = reset_n & reg_wr_en_q & (write_reg_q == readReg0);
  assign fwdHit1  = reset_n & reg_wr_en_q & (write_reg_q == readReg1);
  assign fwdData0 = write_data_q;
  assign fwdData1 = write_data_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed self-checking bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0Valid, req1Valid;
  logic [4:0]  req0Reg, req1Reg;
  logic [63:0] req0Data, req1Data;
  logic        req0Ready, req1Ready;
  logic [4:0]  readReg0, readReg1;
  logic        fwdHit0, fwdHit1;
  logic [63:0] fwdData0, fwdData1;
  logic [4:0]  writeReg;
  logic [63:0] writeData;
  logic        regWrEn;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] rf [32];

  always #5 clk = ~clk;

  regfile_wr_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req0Valid (req0Valid),
    .req0Reg   (req0Reg),
    .req0Data  (req0Data),
    .req0Ready (req0Ready),
    .req1Valid (req1Valid),
    .req1Reg   (req1Reg),
    .req1Data  (req1Data),
    .req1Ready (req1Ready),
    .readReg0  (readReg0),
    .readReg1  (readReg1),
    .fwdHit0   (fwdHit0),
    .fwdHit1   (fwdHit1),
    .fwdData0  (fwdData0),
    .fwdData1  (fwdData1),
    .writeReg  (writeReg),
    .writeData (writeData),
    .regWrEn   (regWrEn)
  );

  // Behavioural regfile fed by the DUT write port.
  always @(posedge clk) begin
    if (regWrEn) rf[writeReg] <= writeData;
  end

  function automatic logic [63:0] rf_rd(input logic [4:0] a);
    return (a == 5'd31) ? 64'd0 : rf[a];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_g [4]  = '{0, 1, 0, 1};
    int exp_wr [4] = '{1, 3, 2, 4};
    int r0_idx, r1_idx;
    logic [4:0] r0_regs [2];
    logic [4:0] r1_regs [2];
    r0_regs[0] = 5'd1; r0_regs[1] = 5'd2;
    r1_regs[0] = 5'd3; r1_regs[1] = 5'd4;

    for (int i = 0; i < 32; i++) rf[i] = 64'd0;

    // Reset held with both requesters valid
    reset_n   = 1'b0;
    req0Valid = 1'b1; req0Reg = 5'd6; req0Data = 64'h66;
    req1Valid = 1'b1; req1Reg = 5'd7; req1Data = 64'h77;
    readReg0  = 5'd0; readReg1 = 5'd6;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req0Ready", req0Ready, 1'b0);
    check("rst_req1Ready", req1Ready, 1'b0);
    check("rst_regWrEn",   regWrEn,   1'b0);
    check("rst_writeReg",  writeReg,  5'd0);
    check("rst_writeData", writeData, 64'd0);
    check("rst_fwdHit0",   fwdHit0,   1'b0);
    check("rst_fwdHit1",   fwdHit1,   1'b0);
    req0Valid = 1'b0; req1Valid = 1'b0;
    reset_n   = 1'b1;
    tick();

    // Contention: grants alternate starting with requester 0
    r0_idx = 0; r1_idx = 0;
    for (int k = 0; k < 4; k++) begin
      req0Valid = (r0_idx < 2);
      req0Reg   = r0_regs[r0_idx < 2 ? r0_idx : 1];
      req0Data  = 64'h11 * {59'd0, req0Reg};
      req1Valid = (r1_idx < 2);
      req1Reg   = r1_regs[r1_idx < 2 ? r1_idx : 1];
      req1Data  = 64'h11 * {59'd0, req1Reg};
      #3;
      check($sformatf("cont%0d_req0Ready", k), req0Ready, exp_g[k] == 0);
      check($sformatf("cont%0d_req1Ready", k), req1Ready, exp_g[k] == 1);
      tick();
      if (exp_g[k] == 0) r0_idx++; else r1_idx++;
      check($sformatf("cont%0d_writeReg", k), writeReg, exp_wr[k]);
      check($sformatf("cont%0d_writeData", k), writeData, 64'h11 * exp_wr[k]);
      check($sformatf("cont%0d_regWrEn", k), regWrEn, 1'b1);
    end
    req0Valid = 1'b0; req1Valid = 1'b0;
    tick();
    check("cont_rf_x1", rf_rd(5'd1), 64'h11);
    check("cont_rf_x2", rf_rd(5'd2), 64'h22);
    check("cont_rf_x3", rf_rd(5'd3), 64'h33);
    check("cont_rf_x4", rf_rd(5'd4), 64'h44);
    check("cont_idle_regWrEn", regWrEn, 1'b0);

    // Single requester 0 writes X5
    req0Valid = 1'b1; req0Reg = 5'd5; req0Data = 64'hA0;
    #3;
    check("single_req0Ready", req0Ready, 1'b1);
    check("single_req1Ready", req1Ready, 1'b0);
    tick();
    req0Valid = 1'b0;
    check("single_regWrEn",   regWrEn,   1'b1);
    check("single_writeReg",  writeReg,  5'd5);
    check("single_writeData", writeData, 64'hA0);
    tick();
    check("single_rf_x5",   rf_rd(5'd5), 64'hA0);
    check("single_idle_en", regWrEn,     1'b0);

    // Zero register write from requester 1
    readReg0  = 5'd31; readReg1 = 5'd31;
    req1Valid = 1'b1; req1Reg = 5'd31; req1Data = 64'hFF;
    #3;
    check("zero_req1Ready", req1Ready, 1'b1);
    tick();
    req1Valid = 1'b0;
    check("zero_regWrEn",   regWrEn,   1'b0);
    check("zero_writeReg",  writeReg,  5'd31);
    check("zero_writeData", writeData, 64'hFF);
    check("zero_fwdHit0",   fwdHit0,   1'b0);
    check("zero_fwdHit1",   fwdHit1,   1'b0);
    tick();
    check("zero_rf_x31", rf_rd(5'd31), 64'd0);

    // Forwarding window for X7
    readReg0  = 5'd7; readReg1 = 5'd8;
    req0Valid = 1'b1; req0Reg = 5'd7; req0Data = 64'h1234;
    #3;
    check("fwd_req0Ready", req0Ready, 1'b1);
    check("fwd_pre_hit0",  fwdHit0,   1'b0);
    tick();
    req0Valid = 1'b0;
    check("fwd_hit0",  fwdHit0,  1'b1);
    check("fwd_data0", fwdData0, 64'h1234);
    check("fwd_hit1",  fwdHit1,  1'b0);
    tick();
    check("fwd_post_hit0", fwdHit0,     1'b0);
    check("fwd_rf_x7",     rf_rd(5'd7), 64'h1234);

    // Reset while requester 1 presents X9: request discarded
    readReg0  = 5'd9;
    req1Valid = 1'b1; req1Reg = 5'd9; req1Data = 64'h99;
    reset_n   = 1'b0;
    #3;
    check("mrst_req1Ready", req1Ready, 1'b0);
    tick();
    req1Valid = 1'b0;
    check("mrst_regWrEn", regWrEn, 1'b0);
    check("mrst_fwdHit0", fwdHit0, 1'b0);
    reset_n = 1'b1;
    tick();
    check("mrst_rf_x9", rf_rd(5'd9), 64'd0);

    // lastGrant restored to 1: requester 0 wins the next contention
    req0Valid = 1'b1; req0Reg = 5'd10; req0Data = 64'hA;
    req1Valid = 1'b1; req1Reg = 5'd11; req1Data = 64'hB;
    #3;
    check("mrst_grant_req0", req0Ready, 1'b1);
    check("mrst_grant_req1", req1Ready, 1'b0);
    tick();
    req0Valid = 1'b0; req1Valid = 1'b0;
    check("mrst_writeReg", writeReg, 5'd10);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
